// File: rtl/tc_pkg.sv
// Shared encodings and sizing for the tensor-core operand loader.
// Default geometry, FSM state codes and beat/counter sizing helpers.
package tc_pkg;

    localparam int TC_M              = 16;
    localparam int TC_N              = 16;
    localparam int TC_K              = 16;
    localparam int TC_DW_IN          = 8;
    localparam int TC_LANES          = 16;
    localparam int TC_LOAD_WAIT      = 3;
    localparam int TC_COMPUTE_CYCLES = 48;

    localparam logic [2:0] ST_FILL_A    = 3'd0;
    localparam logic [2:0] ST_FILL_B    = 3'd1;
    localparam logic [2:0] ST_LOAD      = 3'd2;
    localparam logic [2:0] ST_LOAD_WAIT = 3'd3;
    localparam logic [2:0] ST_COMPUTE   = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    function automatic int tc_beats(input int rows, input int cols, input int lanes);
        return (rows * cols) / lanes;
    endfunction

    // Never returns 0 so a one-entry counter still gets a real bit.
    function automatic int tc_clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    localparam int TC_BA = tc_beats(TC_M, TC_K, TC_LANES);
    localparam int TC_BB = tc_beats(TC_K, TC_N, TC_LANES);

endpackage

// File: rtl/tc_operand_loader_if.sv
// Operand beat stream between an upstream source and the loader.
interface tc_operand_loader_if
    import tc_pkg::*;
#(
    parameter int LANES = TC_LANES,
    parameter int DW_IN = TC_DW_IN
) ();

    logic                   s_valid;
    logic                   s_ready;
    logic [LANES*DW_IN-1:0] s_data;
    logic                   s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/tc_beat_writer.sv
// Flat operand register written one stream beat at a time by beat index.
module tc_beat_writer #(
    parameter int TOTAL_W   = 2048,
    parameter int BEAT_BITS = 128,
    parameter int IDX_W     = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IDX_W-1:0]     idx,
    input  logic [BEAT_BITS-1:0] din,
    output logic [TOTAL_W-1:0]   buf_q
);

    logic [TOTAL_W-1:0] buf_d;

    always_comb begin
        buf_d = buf_q;
        if (we) begin
            buf_d[int'(idx) * BEAT_BITS +: BEAT_BITS] = din;
        end
    end

    // Operand storage is deliberately not reset; it is refilled every job.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule

// File: rtl/tc_operand_loader.sv
// Assembles A/B operand matrices from a beat stream and sequences the core.
//   state     | meaning
//   FILL_A    | accepting A beats into core_in_a
//   FILL_B    | accepting B beats into core_in_b
//   LOAD      | one-cycle core_load_en
//   LOAD_WAIT | settle LOAD_WAIT cycles before compute
//   COMPUTE   | core_compute_en on first cycle, COMPUTE_CYCLES total
//   DONE      | one-cycle done pulse, then back to FILL_A
module tc_operand_loader
    import tc_pkg::*;
#(
    parameter int M              = TC_M,
    parameter int N              = TC_N,
    parameter int K              = TC_K,
    parameter int DW_IN          = TC_DW_IN,
    parameter int LANES          = TC_LANES,
    parameter int LOAD_WAIT      = TC_LOAD_WAIT,
    parameter int COMPUTE_CYCLES = TC_COMPUTE_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    tc_operand_loader_if.slave   s,
    output logic                 core_load_en,
    output logic                 core_compute_en,
    output logic [M*K*DW_IN-1:0] core_in_a,
    output logic [K*N*DW_IN-1:0] core_in_b,
    output logic                 busy,
    output logic                 done,
    output logic                 err_last
);

    localparam int BA       = tc_beats(M, K, LANES);
    localparam int BB       = tc_beats(K, N, LANES);
    localparam int BEAT_W   = tc_clog2_min1((BA > BB) ? BA : BB);
    localparam int WAIT_MAX = (LOAD_WAIT > COMPUTE_CYCLES) ? LOAD_WAIT : COMPUTE_CYCLES;
    localparam int WAIT_W   = tc_clog2_min1(WAIT_MAX);

    localparam logic [BEAT_W-1:0] BA_LAST  = BEAT_W'(BA - 1);
    localparam logic [BEAT_W-1:0] BB_LAST  = BEAT_W'(BB - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);
    localparam logic [WAIT_W-1:0] LW_INIT  = WAIT_W'(LOAD_WAIT - 1);
    localparam logic [WAIT_W-1:0] CC_INIT  = WAIT_W'(COMPUTE_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    logic [2:0]        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic              s_ready_q, s_ready_d;
    logic              accept, we_a, we_b, final_beat;

    assign accept = s.s_valid & s_ready_q & ~reset;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        wait_d     = wait_q;
        err_d      = err_q;
        we_a       = 1'b0;
        we_b       = 1'b0;
        final_beat = (state_q == ST_FILL_B) && (beat_q == BB_LAST);
        // Framing is by count; a misplaced s_last only flags, never reframes.
        if (accept && (s.s_last != final_beat)) begin
            err_d = 1'b1;
        end
        case (state_q)
            ST_FILL_A: begin
                if (accept) begin
                    we_a = 1'b1;
                    if (beat_q == BA_LAST) begin
                        beat_d  = '0;
                        state_d = ST_FILL_B;
                    end else begin
                        beat_d = beat_q + BEAT_ONE;
                    end
                end
            end
            ST_FILL_B: begin
                if (accept) begin
                    we_b = 1'b1;
                    if (beat_q == BB_LAST) begin
                        beat_d  = '0;
                        state_d = ST_LOAD;
                    end else begin
                        beat_d = beat_q + BEAT_ONE;
                    end
                end
            end
            ST_LOAD: begin
                if (LOAD_WAIT == 0) begin
                    state_d = ST_COMPUTE;
                    wait_d  = CC_INIT;
                end else begin
                    state_d = ST_LOAD_WAIT;
                    wait_d  = LW_INIT;
                end
            end
            ST_LOAD_WAIT: begin
                if (wait_q == '0) begin
                    state_d = ST_COMPUTE;
                    wait_d  = CC_INIT;
                end else begin
                    wait_d = wait_q - WAIT_ONE;
                end
            end
            ST_COMPUTE: begin
                if (wait_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    wait_d = wait_q - WAIT_ONE;
                end
            end
            ST_DONE:  state_d = ST_FILL_A;
            default:  state_d = ST_FILL_A;
        endcase
        s_ready_d = (state_d == ST_FILL_A) || (state_d == ST_FILL_B);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FILL_A;
            beat_q    <= '0;
            wait_q    <= '0;
            err_q     <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
            s_ready_q <= s_ready_d;
        end
    end

    tc_beat_writer #(
        .TOTAL_W  (M*K*DW_IN),
        .BEAT_BITS(LANES*DW_IN),
        .IDX_W    (BEAT_W)
    ) u_writer_a (
        .clk  (clk),
        .we   (we_a),
        .idx  (beat_q),
        .din  (s.s_data),
        .buf_q(core_in_a)
    );

    tc_beat_writer #(
        .TOTAL_W  (K*N*DW_IN),
        .BEAT_BITS(LANES*DW_IN),
        .IDX_W    (BEAT_W)
    ) u_writer_b (
        .clk  (clk),
        .we   (we_b),
        .idx  (beat_q),
        .din  (s.s_data),
        .buf_q(core_in_b)
    );

    assign s.s_ready       = s_ready_q;
    assign core_load_en    = (state_q == ST_LOAD);
    assign core_compute_en = (state_q == ST_COMPUTE) && (wait_q == CC_INIT);
    assign busy            = (state_q == ST_LOAD) || (state_q == ST_LOAD_WAIT) ||
                             (state_q == ST_COMPUTE);
    assign done            = (state_q == ST_DONE);
    assign err_last        = err_q;

endmodule

// File: tb/tb_tc_operand_loader.sv
// Directed bench for tc_operand_loader: fill, framing, sequencing and reset cases.
module tb_tc_operand_loader;
    import tc_pkg::*;

    localparam int BEAT = TC_LANES * TC_DW_IN;
    localparam int AW   = TC_M * TC_K * TC_DW_IN;
    localparam int BW   = TC_K * TC_N * TC_DW_IN;
    localparam int NB   = TC_BA + TC_BB;
    localparam int LAT  = 53;   // LOAD + 3 wait + 48 compute + DONE, from the accepting cycle

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          core_load_en, core_compute_en, busy, done, err_last;
    logic [AW-1:0] core_in_a;
    logic [BW-1:0] core_in_b;
    logic [AW-1:0] model_a;
    logic [BW-1:0] model_b;
    int            cyc      = 0;
    int            n_checks = 0;
    int            n_fail   = 0;

    tc_operand_loader_if #(.LANES(TC_LANES), .DW_IN(TC_DW_IN)) s_if ();

    tc_operand_loader #(
        .M(TC_M), .N(TC_N), .K(TC_K), .DW_IN(TC_DW_IN), .LANES(TC_LANES),
        .LOAD_WAIT(3), .COMPUTE_CYCLES(48)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .s              (s_if),
        .core_load_en   (core_load_en),
        .core_compute_en(core_compute_en),
        .core_in_a      (core_in_a),
        .core_in_b      (core_in_b),
        .busy           (busy),
        .done           (done),
        .err_last       (err_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        int k;
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            k = 0;
            while (k < AW/8 - 1 && obs[k*8 +: 8] === exp[k*8 +: 8]) k++;
            $error("FAIL %s: byte %0d observed %0h expected %0h", tag, k, obs[k*8 +: 8], exp[k*8 +: 8]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Job 1: A=i+j, B=i^j. Job 2: A=16i+j, B=255-i-j. Jobs 3/4: marker patterns.
    function automatic logic [BEAT-1:0] beat_data(input int job, input int mat, input int b);
        logic [BEAT-1:0] d;
        d = '0;
        for (int l = 0; l < TC_LANES; l++) begin
            if (job == 1)      d[l*8 +: 8] = (mat == 0) ? 8'(b + l) : 8'(b ^ l);
            else if (job == 2) d[l*8 +: 8] = (mat == 0) ? 8'(b*16 + l) : 8'(255 - b - l);
            else if (job == 3) d[l*8 +: 8] = 8'h5A;
            else               d[l*8 +: 8] = 8'(8'hC3 ^ l);
        end
        return d;
    endfunction

    task automatic put_beat(input logic [BEAT-1:0] d, input logic last, output int acc_cyc);
        int t;
        t = 0;
        s_if.s_valid = 1'b1;
        s_if.s_data  = d;
        s_if.s_last  = last;
        while (s_if.s_ready !== 1'b1 && t < 200) begin
            step();
            t++;
        end
        chk("ready_wait", (t < 200), 1);
        step();
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic send_job(input int job, input int start_b, input int extra_last, input bit gap,
                            input bit track, output int first_acc, output int last_acc);
        int acc, mat, bi;
        logic [BEAT-1:0] d;
        first_acc = 0;
        last_acc  = 0;
        for (int b = start_b; b < NB; b++) begin
            mat = (b < TC_BA) ? 0 : 1;
            bi  = (b < TC_BA) ? b : b - TC_BA;
            d   = beat_data(job, mat, bi);
            put_beat(d, (b == NB - 1) || (b == extra_last), acc);
            if (mat == 0) model_a[bi*BEAT +: BEAT] = d;
            else          model_b[bi*BEAT +: BEAT] = d;
            if (b == start_b) first_acc = acc;
            last_acc = acc;
            if (b == extra_last - 1) chk("err_before_early_last", err_last, 0);
            if (b == extra_last)     chk("err_after_early_last", err_last, 1);
            if (track) begin
                chk_bus("replace_a", core_in_a, model_a);
                chk_bus("replace_b", core_in_b, model_b);
            end
            if (gap && b != NB - 1) step();
        end
    endtask

    // Entered right after the edge that accepted the final B beat.
    task automatic run_ctrl(input string tag, input int last_acc);
        int t;
        bit rdy_seen;
        logic [AW-1:0] sa;
        logic [BW-1:0] sb;
        sa = core_in_a;
        sb = core_in_b;
        chk({tag, "_load_en"}, core_load_en, 1);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_ready_low"}, s_if.s_ready, 0);
        step();
        chk({tag, "_load_drop"}, core_load_en, 0);
        chk({tag, "_compute_early"}, core_compute_en, 0);
        step(); step(); step();
        chk({tag, "_compute_en"}, core_compute_en, 1);
        step();
        chk({tag, "_compute_drop"}, core_compute_en, 0);
        t = 0;
        rdy_seen = 1'b0;
        while (done !== 1'b1 && t < 200) begin
            if (s_if.s_ready !== 1'b0) rdy_seen = 1'b1;
            step();
            t++;
        end
        chk({tag, "_done_latency"}, cyc - last_acc + 1, LAT);
        chk({tag, "_ready_in_busy"}, rdy_seen, 0);
        chk({tag, "_busy_in_done"}, busy, 0);
        chk_bus({tag, "_a_stable"}, core_in_a, sa);
        chk_bus({tag, "_b_stable"}, core_in_b, sb);
        step();
        chk({tag, "_done_drop"}, done, 0);
        chk({tag, "_ready_after"}, s_if.s_ready, 1);
    endtask

    initial begin
        int fa, la, t;
        bit seen;
        logic [BEAT-1:0] d;
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        s_if.s_last  = 1'b0;
        model_a = 'x;
        model_b = 'x;

        reset = 1'b1;
        step(); step();
        chk("rst_ready", s_if.s_ready, 0);
        chk("rst_load", core_load_en, 0);
        chk("rst_compute", core_compute_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_last, 0);
        reset = 1'b0;
        step();
        chk("rst_ready_after", s_if.s_ready, 1);

        // Back-to-back job
        send_job(1, 0, -1, 1'b0, 1'b0, fa, la);
        chk("fill_b2b_cycles", la - fa, 31);
        chk("a_3_5_job1", core_in_a[(3*TC_K + 5)*8 +: 8], 8);
        chk("b_3_5_job1", core_in_b[(3*TC_N + 5)*8 +: 8], 6);
        chk_bus("bus_a_job1", core_in_a, model_a);
        chk_bus("bus_b_job1", core_in_b, model_b);
        run_ctrl("b2b", la);
        chk("err_b2b", err_last, 0);

        // Same job with a one-cycle gap after every beat
        send_job(1, 0, -1, 1'b1, 1'b0, fa, la);
        chk("fill_gap_cycles", la - fa, 62);
        chk_bus("bus_a_gap", core_in_a, model_a);
        chk_bus("bus_b_gap", core_in_b, model_b);
        run_ctrl("gap", la);

        // Early s_last on beat 15
        send_job(1, 0, 15, 1'b0, 1'b0, fa, la);
        run_ctrl("frame", la);
        chk("err_sticky_after_done", err_last, 1);

        // Reset in compute cycle 10
        send_job(1, 0, -1, 1'b0, 1'b0, fa, la);
        step(); step(); step(); step();
        chk("rstc_compute_en", core_compute_en, 1);
        repeat (9) step();
        chk("rstc_busy_before", busy, 1);
        reset = 1'b1;
        step();
        chk("rstc_busy", busy, 0);
        chk("rstc_compute", core_compute_en, 0);
        chk("rstc_done", done, 0);
        chk("rstc_ready_in_reset", s_if.s_ready, 0);
        chk("rstc_err_cleared", err_last, 0);
        reset = 1'b0;
        step();
        chk("rstc_ready_after", s_if.s_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        chk("rstc_no_done", seen, 0);

        // Partial fill discarded by reset
        for (int b = 0; b < 3; b++) begin
            d = beat_data(3, 0, b);
            put_beat(d, 1'b0, t);
            model_a[b*BEAT +: BEAT] = d;
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();

        // Second job replaces buses beat by beat; s_valid held through busy
        send_job(2, 0, -1, 1'b0, 1'b1, fa, la);
        chk("a_3_5_job2", core_in_a[(3*TC_K + 5)*8 +: 8], 8'h35);
        chk("b_3_5_job2", core_in_b[(3*TC_N + 5)*8 +: 8], 8'hF7);
        d = beat_data(4, 0, 0);
        s_if.s_valid = 1'b1;
        s_if.s_data  = d;
        s_if.s_last  = 1'b0;
        run_ctrl("job2", la);
        step();
        s_if.s_valid = 1'b0;
        model_a[0 +: BEAT] = d;
        chk_bus("held_beat_offset0", core_in_a, model_a);
        send_job(1, 1, -1, 1'b0, 1'b0, fa, la);
        chk_bus("bus_a_job3", core_in_a, model_a);
        chk_bus("bus_b_job3", core_in_b, model_b);
        run_ctrl("job3", la);
        chk("err_job3", err_last, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
